// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Immediate-format definitions shared by the immediate extender
//               and the immediate encoder. It provides the format code enum,
//               the instruction-bit mask of each format's immediate field, and
//               one pack function per format that places immediate bits into
//               instruction bits [31:7].
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Format codes. Codes 0, 6 and 7 are illegal.
    typedef enum logic [2:0] {
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_src_e;

    // Instruction bits that carry immediate data, per format.
    localparam logic [31:0] C_MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] C_MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] C_MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] C_MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] C_MASK_J = 32'hFFFF_F000;

    // I: [31:20] = imm[11:0]
    function automatic logic [31:0] pack_i(input logic [31:0] imm);
        return {imm[11:0], 20'h0_0000};
    endfunction

    // S: [31:25] = imm[11:5], [11:7] = imm[4:0]
    function automatic logic [31:0] pack_s(input logic [31:0] imm);
        return {imm[11:5], 13'h0000, imm[4:0], 7'h00};
    endfunction

    // B: [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11]
    function automatic logic [31:0] pack_b(input logic [31:0] imm);
        return {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
    endfunction

    // U: [31:12] = imm[31:12]
    function automatic logic [31:0] pack_u(input logic [31:0] imm);
        return {imm[31:12], 12'h000};
    endfunction

    // J: [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12]
    function automatic logic [31:0] pack_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
    endfunction

    // Field mask by format code; illegal codes own no bits, so Base passes
    // through untouched.
    function automatic logic [31:0] imm_mask(input logic [2:0] src);
        case (src)
            IMM_I:   return C_MASK_I;
            IMM_S:   return C_MASK_S;
            IMM_B:   return C_MASK_B;
            IMM_U:   return C_MASK_U;
            IMM_J:   return C_MASK_J;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Packed field by format code; illegal codes produce an empty field.
    function automatic logic [31:0] imm_pack(input logic [2:0] src,
                                             input logic [31:0] imm);
        case (src)
            IMM_I:   return pack_i(imm);
            IMM_S:   return pack_s(imm);
            IMM_B:   return pack_b(imm);
            IMM_U:   return pack_u(imm);
            IMM_J:   return pack_j(imm);
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_range_check.sv
`default_nettype none
// ============================================================================
// Module      : imm_range_check
// Description : Combinational representability check. Reports whether an
//               immediate value can be encoded exactly in the given format.
// Ports       : ImmSrc [2:0]  in  format code (1=I 2=S 3=B 4=U 5=J)
//               ImmVal [31:0] in  immediate value
//               legal         out 1 = representable and format code legal
// Revision    : 1.0 - initial release
// ============================================================================
module imm_range_check
    import imm_pkg::*;
(
    input  logic [2:0]  ImmSrc,
    input  logic [31:0] ImmVal,
    output logic        legal
);

    // A value fits an N-bit signed field when every bit from the field's
    // sign position upward is a copy of the sign, i.e. all ones or all zeros.
    logic w_sx12;   // [31:11] uniform: 12-bit signed (I, S)
    logic w_sx13;   // [31:12] uniform: 13-bit signed (B)
    logic w_sx21;   // [31:20] uniform: 21-bit signed (J)

    assign w_sx12 = (&ImmVal[31:11]) | ~(|ImmVal[31:11]);
    assign w_sx13 = (&ImmVal[31:12]) | ~(|ImmVal[31:12]);
    assign w_sx21 = (&ImmVal[31:20]) | ~(|ImmVal[31:20]);

    always_comb begin
        legal = 1'b0;
        case (ImmSrc)
            IMM_I,
            IMM_S:   legal = w_sx12;
            // Branch and jump offsets are halfword aligned; bit 0 is not encoded.
            IMM_B:   legal = w_sx13 & ~ImmVal[0];
            IMM_U:   legal = ~(|ImmVal[11:0]);
            IMM_J:   legal = w_sx21 & ~ImmVal[0];
            default: legal = 1'b0;
        endcase
    end

endmodule : imm_range_check
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Inverse of the immediate extender. Packs a 32-bit immediate
//               into instruction bits [31:7] according to a format code,
//               merged with a caller-supplied base word, and flags values the
//               format cannot represent. Two-stage valid/ready pipeline:
//               S1 registers the request and its range check, S2 registers
//               the packed instruction.
// Ports       : CLK, RST_N          clock, asynchronous active-low reset
//               in_valid / in_ready request handshake
//               ImmSrc [2:0]        format code (1=I 2=S 3=B 4=U 5=J)
//               ImmVal [31:0]       immediate value
//               Base   [31:0]       non-immediate instruction bits
//               out_valid/out_ready result handshake
//               Instr  [31:0]       encoded instruction
//               ImmErr              immediate unrepresentable / bad format
//               ErrCnt [ERR_CNT_W]  saturating count of errored results
//                                   (only with IMM_ENC_ERRCNT_EN)
// Config      : `define IMM_ENC_ERRCNT_EN to add the ErrCnt port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import imm_pkg::*;
#(
    parameter int ERR_CNT_W = 16
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  ImmSrc,
    input  logic [31:0] ImmVal,
    input  logic [31:0] Base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Instr,
    output logic        ImmErr
`ifdef IMM_ENC_ERRCNT_EN
  , output logic [ERR_CNT_W-1:0] ErrCnt
`endif
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic        r_s1_valid;
    logic        r_s2_valid;
    logic        w_s2_load;
    logic        w_s1_load;

    // S2 can take new data when it is empty or its content leaves this
    // cycle; S1 can take new data when it is empty or drains into S2.
    // in_ready therefore depends combinationally on out_ready, which keeps
    // the pipe at full rate without a skid buffer.
    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: register request and representability
    // ------------------------------------------------------------------
    logic        w_legal;
    logic        r_s1_legal;
    logic [2:0]  r_s1_src;
    logic [31:0] r_s1_imm;
    logic [31:0] r_s1_base;

    imm_range_check u_range_check (
        .ImmSrc (ImmSrc),
        .ImmVal (ImmVal),
        .legal  (w_legal)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_legal <= 1'b0;
            r_s1_src   <= 3'd0;
            r_s1_imm   <= 32'h0000_0000;
            r_s1_base  <= 32'h0000_0000;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            // Payload only moves on an actual accept, so an idle bubble
            // does not toggle the datapath.
            if (in_valid) begin
                r_s1_legal <= w_legal;
                r_s1_src   <= ImmSrc;
                r_s1_imm   <= ImmVal;
                r_s1_base  <= Base;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pack into the base word
    // ------------------------------------------------------------------
    logic [31:0] w_mask;
    logic [31:0] w_field;
    logic [31:0] w_instr;

    // The base word's field bits are always cleared; on an error the field
    // stays all-zero rather than carrying a truncated value. Illegal format
    // codes have an empty mask, so the base passes through unchanged.
    assign w_mask  = imm_mask(r_s1_src);
    assign w_field = r_s1_legal ? imm_pack(r_s1_src, r_s1_imm) : 32'h0000_0000;
    assign w_instr = (r_s1_base & ~w_mask) | w_field;

    logic [31:0] r_instr;
    logic        r_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s2_valid <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_err      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            // Hold the last result when a bubble moves in.
            if (r_s1_valid) begin
                r_instr <= w_instr;
                r_err   <= ~r_s1_legal;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign Instr     = r_instr;
    assign ImmErr    = r_err;

    // ------------------------------------------------------------------
    // Optional rejected-request counter
    // ------------------------------------------------------------------
`ifdef IMM_ENC_ERRCNT_EN
    localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = {ERR_CNT_W{1'b1}};

    logic                 w_err_fire;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Counted on the output handshake so a stalled result counts once.
    assign w_err_fire = r_s2_valid & out_ready & r_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err_cnt <= '0;
        end else if (w_err_fire && (r_err_cnt != C_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign ErrCnt = r_err_cnt;
`endif

endmodule : imm_encoder
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder. Directed table vectors,
//               latency, backpressure and mid-flight reset sequences, then a
//               randomized round trip through a behavioural extender model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ImmSrc = 3'd0;
    logic [31:0] ImmVal = 32'h0;
    logic [31:0] Base = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Instr;
    logic        ImmErr;

    localparam int c_cnt_w = 4;
`ifdef IMM_ENC_ERRCNT_EN
    logic [c_cnt_w-1:0] ErrCnt;
`endif
    int model_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    imm_encoder #(.ERR_CNT_W(c_cnt_w)) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .ImmVal    (ImmVal),
        .Base      (Base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Instr     (Instr),
        .ImmErr    (ImmErr)
`ifdef IMM_ENC_ERRCNT_EN
      , .ErrCnt    (ErrCnt)
`endif
    );

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
    } req_t;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    // ---------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------
    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Representability from numeric ranges of each format.
    function automatic logic model_err(input logic [2:0] src, input logic [31:0] imm);
        int s;
        s = signed'(imm);
        case (src)
            3'd1, 3'd2: return !(s >= -2048 && s <= 2047);
            3'd3:       return !(s >= -4096 && s <= 4094 && (s % 2 == 0));
            3'd4:       return (imm % 4096) != 0;
            3'd5:       return !(s >= -1048576 && s <= 1048574 && (s % 2 == 0));
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_mask(input logic [2:0] src);
        case (src)
            3'd1:       return 32'hFFF00000;
            3'd2, 3'd3: return 32'hFE000F80;
            3'd4, 3'd5: return 32'hFFFFF000;
            default:    return 32'h0;
        endcase
    endfunction

    // Immediate extender: recovers the immediate from an instruction.
    function automatic logic [31:0] model_ext(input logic [2:0] src, input logic [31:0] ins);
        case (src)
            3'd1:    return {{20{ins[31]}}, ins[31:20]};
            3'd2:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd3:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd4:    return {ins[31:12], 12'h000};
            3'd5:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_txn(input req_t r, input logic [31:0] ins, input logic err, input string tag);
        logic        e;
        logic [31:0] m;
        e = model_err(r.src, r.imm);
        m = model_mask(r.src);
        chk_eq({tag, ".err"}, {31'h0, err}, {31'h0, e});
        chk_eq({tag, ".keep"}, ins & ~m, r.base & ~m);
        if (e) chk_eq({tag, ".zero"}, ins & m, 32'h0);
        else   chk_eq({tag, ".rt"}, model_ext(r.src, ins), r.imm);
    endtask

    task automatic note_out(input logic err);
        if (err && model_cnt < (1 << c_cnt_w) - 1) model_cnt++;
    endtask

    task automatic drive(input req_t r);
        ImmSrc = r.src;
        ImmVal = r.imm;
        Base   = r.base;
    endtask

    // One isolated transaction with out_ready held high.
    task automatic run_one(input req_t r, output logic [31:0] ins, output logic err);
        int n;
        @(negedge CLK);
        drive(r);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge CLK); #1; n++;
        end
        if (n >= 20) chk_eq("one.accept_timeout", {31'h0, in_ready}, 32'h1);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge CLK); #1; n++;
        end
        if (n >= 20) chk_eq("one.out_timeout", {31'h0, out_valid}, 32'h1);
        ins = Instr;
        err = ImmErr;
        note_out(err);
        @(posedge CLK);
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    vec_t tbl[10];
    req_t q[$];

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        int          sh;
        v  = $urandom;
        sh = $urandom_range(31, 9);
        case ($urandom_range(3))
            0:       return v;
            1:       return 32'(signed'(v) >>> sh);
            2:       return 32'(signed'(v) >>> sh) & 32'hFFFFFFFE;
            default: return v & 32'hFFFFF000;
        endcase
    endfunction

    initial begin
        req_t        r, ra, rb, rc;
        logic [31:0] ins;
        logic        err;
        logic [31:0] res_i[$];
        logic        res_e[$];
        bit          c_acc;
        int          n;

        tbl[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
        tbl[1] = '{3'd3, 32'h00000800, 32'h00000063, 32'h000000E3, 1'b0};
        tbl[2] = '{3'd3, 32'h00000801, 32'h00000063, 32'h00000063, 1'b1};
        tbl[3] = '{3'd4, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0};
        tbl[4] = '{3'd5, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0};
        tbl[5] = '{3'd4, 32'h12345001, 32'h00000037, 32'h00000037, 1'b1};
        tbl[6] = '{3'd2, 32'hFFFFF800, 32'h00000023, 32'h80000023, 1'b0};
        tbl[7] = '{3'd2, 32'h00000800, 32'hFFFFFFFF, 32'h01FFF07F, 1'b1};
        tbl[8] = '{3'd0, 32'h00000004, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        tbl[9] = '{3'd5, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0};

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        chk_eq("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk_eq("rst.instr", Instr, 32'h0);
        chk_eq("rst.err", {31'h0, ImmErr}, 32'h0);
        chk_eq("rst.in_ready", {31'h0, in_ready}, 32'h1);
`ifdef IMM_ENC_ERRCNT_EN
        chk_eq("rst.errcnt", 32'(ErrCnt), 32'h0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;

        // Latency: accept in cycle N, out_valid in cycle N+2
        @(negedge CLK);
        r = '{tbl[0].src, tbl[0].imm, tbl[0].base};
        drive(r);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk_eq("lat.in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        chk_eq("lat.n1_valid", {31'h0, out_valid}, 32'h0);
        @(negedge CLK);
        #1;
        chk_eq("lat.n2_valid", {31'h0, out_valid}, 32'h1);
        chk_eq("lat.instr", Instr, tbl[0].exp_instr);
        note_out(ImmErr);
        @(posedge CLK);

        // Directed table
        foreach (tbl[i]) begin
            r = '{tbl[i].src, tbl[i].imm, tbl[i].base};
            run_one(r, ins, err);
            chk_eq($sformatf("tbl%0d.instr", i), ins, tbl[i].exp_instr);
            chk_eq($sformatf("tbl%0d.err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
            check_txn(r, ins, err, $sformatf("tbl%0d", i));
        end
`ifdef IMM_ENC_ERRCNT_EN
        chk_eq("tbl.errcnt", 32'(ErrCnt), 32'(model_cnt));
`endif

        // Backpressure: three back-to-back requests against a stalled sink
        ra = '{3'd1, 32'h000007FF, 32'h00000013};
        rb = '{3'd3, 32'h00000801, 32'h00000063};
        rc = '{3'd4, 32'hABCDE000, 32'h00000037};
        @(negedge CLK);
        out_ready = 1'b0;
        drive(ra);
        in_valid = 1'b1;
        #1;
        chk_eq("bp.acc_a", {31'h0, in_ready}, 32'h1);
        @(negedge CLK);
        drive(rb);
        #1;
        chk_eq("bp.acc_b", {31'h0, in_ready}, 32'h1);
        @(negedge CLK);
        drive(rc);
        #1;
        chk_eq("bp.full", {31'h0, in_ready}, 32'h0);
        ins = Instr;
        err = ImmErr;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            chk_eq("bp.stall_ready", {31'h0, in_ready}, 32'h0);
            chk_eq("bp.stall_valid", {31'h0, out_valid}, 32'h1);
            chk_eq("bp.stall_instr", Instr, ins);
            chk_eq("bp.stall_err", {31'h0, ImmErr}, {31'h0, err});
        end
        c_acc = 1'b0;
        n = 0;
        while (res_i.size() < 3 && n < 20) begin
            @(negedge CLK);
            if (c_acc) in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) c_acc = 1'b1;
            if (out_valid && out_ready) begin
                res_i.push_back(Instr);
                res_e.push_back(ImmErr);
                note_out(ImmErr);
            end
            n++;
        end
        in_valid = 1'b0;
        chk_eq("bp.count", 32'(res_i.size()), 32'd3);
        if (res_i.size() == 3) begin
            check_txn(ra, res_i[0], res_e[0], "bp.a");
            check_txn(rb, res_i[1], res_e[1], "bp.b");
            check_txn(rc, res_i[2], res_e[2], "bp.c");
        end
        @(negedge CLK);
        #1;
        chk_eq("bp.drained", {31'h0, out_valid}, 32'h0);

        // Reset with both stages occupied
        @(negedge CLK);
        out_ready = 1'b0;
        drive(rb);
        in_valid = 1'b1;
        @(negedge CLK);
        drive(ra);
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        chk_eq("mf.pre_valid", {31'h0, out_valid}, 32'h1);
        #1;
        RST_N = 1'b0;
        #1;
        chk_eq("mf.out_valid", {31'h0, out_valid}, 32'h0);
        chk_eq("mf.in_ready", {31'h0, in_ready}, 32'h1);
`ifdef IMM_ENC_ERRCNT_EN
        chk_eq("mf.errcnt", 32'(ErrCnt), 32'h0);
`endif
        model_cnt = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        run_one(rc, ins, err);
        chk_eq("mf.post_instr", ins, 32'hABCDE037);
        check_txn(rc, ins, err, "mf.post");

        // Randomized round trip with random valid/ready patterns
        begin
            int          sent, got, cyc;
            bit          acc, stall_prev;
            logic [31:0] pi;
            logic        pe;
            req_t        cur, exp_r;
            sent = 0; got = 0; cyc = 0;
            acc = 1'b0; stall_prev = 1'b0;
            pi = 32'h0; pe = 1'b0;
            cur = '{3'd0, 32'h0, 32'h0};
            in_valid = 1'b0;
            while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
                @(negedge CLK);
                cyc++;
                if (acc) begin
                    in_valid = 1'b0;
                    acc = 1'b0;
                end
                if (!in_valid && sent < 10000 && $urandom_range(3) != 0) begin
                    cur = '{3'($urandom_range(7)), rand_imm(), $urandom};
                    drive(cur);
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(3) != 0);
                #1;
                if (stall_prev) begin
                    chk_eq("rnd.hold_valid", {31'h0, out_valid}, 32'h1);
                    chk_eq("rnd.hold_instr", Instr, pi);
                    chk_eq("rnd.hold_err", {31'h0, ImmErr}, {31'h0, pe});
                end
                stall_prev = out_valid && !out_ready;
                pi = Instr;
                pe = ImmErr;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk_eq("rnd.spurious", 32'h1, 32'h0);
                    end else begin
                        exp_r = q.pop_front();
                        check_txn(exp_r, Instr, ImmErr, "rnd");
                    end
                    note_out(ImmErr);
                    got++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(cur);
                    sent++;
                    acc = 1'b1;
                end
            end
            @(negedge CLK);
            in_valid = 1'b0;
            chk_eq("rnd.count", 32'(got), 32'd10000);
`ifdef IMM_ENC_ERRCNT_EN
            chk_eq("rnd.errcnt", 32'(ErrCnt), 32'(model_cnt));
            chk_eq("rnd.errcnt_sat", 32'(ErrCnt), 32'd15);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_imm_encoder
`default_nettype wire
